scoreboard_hazard_unit: RTL

//  Parametrised hazard/forwarding scoreboard for the in-order pipeline.

---
 rtl/scoreboard_hazard_unit_if.sv | 36 +++
 rtl/scoreboard_hazard_unit.sv | 114 +++++++++++
 2 files changed

// File: rtl/scoreboard_hazard_unit_if.sv
// ID-stage bundle for the hazard/forwarding scoreboard.
// The master side drives the ID instruction, and the slave side returns stall/issue/forward selects.
interface scoreboard_hazard_unit_if #(
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned MAX_LAT = 2
);
    localparam int unsigned AGE_W = $clog2(DEPTH);
    localparam int unsigned LAT_W = $clog2(MAX_LAT + 1);
    localparam int unsigned NREG  = 2 ** REG_AW;

    logic              id_valid;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_use_rs;
    logic              id_use_rt;
    logic              id_wreg;
    logic [REG_AW-1:0] id_rd;
    logic [LAT_W-1:0]  id_lat;
    logic              flush;
    logic              stall;
    logic              issue;
    logic [AGE_W-1:0]  fwda;
    logic [AGE_W-1:0]  fwdb;
    logic [NREG-1:0]   busy_vec;

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wreg, id_rd, id_lat, flush,
        input  stall, issue, fwda, fwdb, busy_vec
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wreg, id_rd, id_lat, flush,
        output stall, issue, fwda, fwdb, busy_vec
    );
endinterface

// File: rtl/scoreboard_hazard_unit.sv
// In-order pipeline hazard scoreboard: per-register age/latency tracking with stall and forwarding.
// Optional HAZARD_STATS_EN adds a saturating stall_cycles counter.
module scoreboard_hazard_unit #(
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned MAX_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
`ifdef HAZARD_STATS_EN
    output logic [31:0] stall_cycles,
`endif
    scoreboard_hazard_unit_if.slave bus
);
    localparam int unsigned AGE_W = $clog2(DEPTH);
    localparam int unsigned LAT_W = $clog2(MAX_LAT + 1);
    localparam int unsigned NREG  = 2 ** REG_AW;

    localparam logic [AGE_W-1:0] AGE_LAST = AGE_W'(DEPTH - 1);
    localparam logic [AGE_W-1:0] AGE_ONE  = AGE_W'(1);
    localparam logic [LAT_W-1:0] LAT_MAX  = LAT_W'(MAX_LAT);

    logic [NREG-1:0]  busy_q, busy_d;
    logic [AGE_W-1:0] age_q [NREG];
    logic [AGE_W-1:0] age_d [NREG];
    logic [LAT_W-1:0] lat_q [NREG];
    logic [LAT_W-1:0] lat_d [NREG];

    logic             hz_a, hz_b;
    logic             not_ready_a, not_ready_b;
    logic [LAT_W-1:0] lat_eff;

    // Operand lookup: a busy source is ready once its age has passed its result latency.
    always_comb begin
        hz_a        = bus.id_use_rs && (bus.id_rs != '0) && busy_q[bus.id_rs];
        hz_b        = bus.id_use_rt && (bus.id_rt != '0) && busy_q[bus.id_rt];
        not_ready_a = hz_a && (age_q[bus.id_rs] <= AGE_W'(lat_q[bus.id_rs]));
        not_ready_b = hz_b && (age_q[bus.id_rt] <= AGE_W'(lat_q[bus.id_rt]));

        bus.fwda  = (hz_a && !not_ready_a) ? age_q[bus.id_rs] : '0;
        bus.fwdb  = (hz_b && !not_ready_b) ? age_q[bus.id_rt] : '0;
        bus.stall = bus.id_valid && (not_ready_a || not_ready_b);
        bus.issue = bus.id_valid && !bus.stall && !bus.flush;

        bus.busy_vec    = busy_q;
        bus.busy_vec[0] = 1'b0;
    end

    assign lat_eff = (bus.id_lat > LAT_MAX) ? LAT_MAX : bus.id_lat;

    // Age every entry, retire at WB, then let a new issue overwrite (issue beats retirement).
    always_comb begin
        busy_d = busy_q;
        for (int unsigned r = 0; r < NREG; r++) begin
            age_d[r] = age_q[r];
            lat_d[r] = lat_q[r];
            if (busy_q[r]) begin
                if (age_q[r] == AGE_LAST) begin
                    busy_d[r] = 1'b0;
                end else begin
                    age_d[r] = age_q[r] + AGE_ONE;
                end
            end
        end
        if (bus.issue && bus.id_wreg && (bus.id_rd != '0)) begin
            busy_d[bus.id_rd] = 1'b1;
            age_d[bus.id_rd]  = AGE_ONE;
            lat_d[bus.id_rd]  = lat_eff;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
            for (int unsigned r = 0; r < NREG; r++) begin
                age_q[r] <= '0;
                lat_q[r] <= '0;
            end
        end else begin
            busy_q <= busy_d;
            for (int unsigned r = 0; r < NREG; r++) begin
                age_q[r] <= age_d[r];
                lat_q[r] <= lat_d[r];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && bus.id_valid && bus.id_wreg && !bus.flush) begin
            assert (bus.id_lat <= LAT_MAX);
        end
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (bus.stall && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
`endif
endmodule
